// File: rtl/cla_pkg.sv
// cla_pkg: shared gp type, group defaults and the lookahead carry function for the pipelined CLA
package cla_pkg;

    localparam int GROUP_DEFAULT = 4;
    localparam int GROUP_MAX     = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Sum-of-products lookahead: carry into bit i+1 is an OR of every generate below it
    // (qualified by the propagates in between) and of cin qualified by all propagates.
    function automatic logic [GROUP_MAX:0] cla_carries(input gp_t [GROUP_MAX-1:0] gp, input logic cin);
        logic [GROUP_MAX:0] c;
        logic               term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP_MAX; i++) begin
            term = cin;
            for (int m = 0; m <= i; m++) term = term & gp[m].p;
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = gp[j].g;
                for (int m = j + 1; m <= i; m++) term = term & gp[m].p;
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: GROUP-bit carry-lookahead block producing sum bits and block generate/propagate
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = GROUP_DEFAULT
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_i,
    output logic [GROUP-1:0] s_o,
    output logic             g_o,
    output logic             p_o
);

    gp_t [GROUP_MAX-1:0] gp;
    logic [GROUP-1:0]    c;

    if (GROUP < 1 || GROUP > GROUP_MAX) begin : g_bad
        $error("cla_group: GROUP must be 1..%0d", GROUP_MAX);
    end

    // Per-bit generate/propagate; entries above GROUP stay zero so they never create carries
    always_comb begin
        gp = '0;
        for (int i = 0; i < GROUP; i++) begin
            gp[i].g = a_i[i] & b_i[i];
            gp[i].p = a_i[i] ^ b_i[i];
        end
    end

    assign c   = GROUP'(cla_carries(gp, c_i));
    assign s_o = a_i ^ b_i ^ c;
    assign p_o = &(a_i ^ b_i);

    // Block generate: a carry leaves the group with no carry entering it
    always_comb begin
        g_o = 1'b0;
        for (int i = 0; i < GROUP; i++) g_o = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & g_o);
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead add/subtract with valid/ready flow control.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = GROUP_DEFAULT,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Ci_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             Co_o
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    logic [STAGES-1:0] v_q, v_d, adv, ld;

    if (STAGES < 1 || WIDTH % (STAGES * GROUP) != 0) begin : g_bad
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP and STAGES >= 1");
    end

    // A stage may move when its successor is empty or moving itself; the last one when the consumer takes it
    always_comb begin
        adv[STAGES-1] = !v_q[STAGES-1] | out_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) adv[k] = !v_q[k] | adv[k+1];
    end

    // A stage loads when it can move and its source holds an operation; otherwise it holds or empties
    always_comb begin
        ld[0] = adv[0] & in_valid_i;
        for (int k = 1; k < STAGES; k++) ld[k] = adv[k] & v_q[k-1];
        for (int k = 0; k < STAGES; k++) v_d[k] = ld[k] | (!adv[k] & v_q[k]);
    end

    // Valid bits; reset discards everything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) v_q <= '0;
        else       v_q <= v_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SW;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]    a_in, b_in;
        logic [WIDTH-1:0] s_in, s_d, s_q;
        logic             c_in, c_d, c_q;
        logic [SW-1:0]    ss;
        logic [NG:0]      gc;
        logic [NG-1:0]    gg, gpp;

        if (k == 0) begin : g_src
            assign a_in = A_i;
            assign b_in = sub_i ? ~B_i : B_i;
            assign c_in = Ci_i ^ sub_i;
            assign s_in = '0;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_rest.a_q;
            assign b_in = g_stg[k-1].g_rest.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign s_in = g_stg[k-1].s_q;
        end

        assign gc[0] = c_in;
        for (genvar i = 0; i < NG; i++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a_i (a_in[i*GROUP +: GROUP]),
                .b_i (b_in[i*GROUP +: GROUP]),
                .c_i (gc[i]),
                .s_o (ss[i*GROUP +: GROUP]),
                .g_o (gg[i]),
                .p_o (gpp[i])
            );
            assign gc[i+1] = gg[i] | (gpp[i] & gc[i]);
        end

        // Slice k result drops into place; finished low bits pass through unchanged
        always_comb begin
            s_d = s_q;
            c_d = c_q;
            if (ld[k]) begin
                s_d           = s_in;
                s_d[LO +: SW] = ss;
                c_d           = gc[NG];
            end
        end

        // Sum/carry register for this stage
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        if (k < STAGES - 1) begin : g_rest
            logic [RW-SW-1:0] a_d, a_q, b_d, b_q;

            // Operands for the still-unsummed upper slices ride along skewed
            always_comb begin
                a_d = ld[k] ? a_in[RW-1:SW] : a_q;
                b_d = ld[k] ? b_in[RW-1:SW] : b_q;
            end

            // Upper-slice operand register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef CLA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d, ovf_q;

            // Signed overflow: operands share a sign that the sum does not
            always_comb ovf_d = ld[k] ? ((a_in[RW-1] == b_in[RW-1]) & (ss[SW-1] != a_in[RW-1])) : ovf_q;

            // Overflow flag register, aligned with the final sum
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) ovf_q <= 1'b0;
                else       ovf_q <= ovf_d;
            end
        end
`endif
    end

    assign in_ready_o  = adv[0];
    assign out_valid_o = v_q[STAGES-1];
    assign S_o         = g_stg[STAGES-1].s_q;
    assign Co_o        = g_stg[STAGES-1].c_q;
`ifdef CLA_PIPE_OVF_EN
    assign ovf_o       = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
